// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int UART_BAUD_DIV = 5208;  // 50 MHz / 9600

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// CPU-side read/status bus of the UART receive buffer.
interface uart_rx_buffer_if;
  import uart_pkg::*;

  logic                   rd_en;
  logic                   clr_err;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   overflow;
  logic                   frame_err;
  logic                   busy;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, overflow, frame_err, busy
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, overflow, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head reads 0 while empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Read/write pointers, wrapping naturally over AW+1 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a FWFT FIFO.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  uart_rx_buffer_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  state_t                 state, state_nx;
  logic                   rx_meta, rxs;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [2:0]             bit_idx, bit_idx_nx;
  logic [UART_DATA_W-1:0] shift, shift_nx;
  logic                   push_req, frame_set;
  logic                   push_q;
  logic [UART_DATA_W-1:0] push_data;
  logic                   fifo_full, fifo_empty, pop, ovf_set;
  logic                   busy, overflow, frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad, par_bad_nx;
`endif

  // Two-flop synchroniser, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, bit timing and deframing decisions.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - CW'(1);
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    push_req   = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nx = START;
          cnt_nx   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_nx = IDLE;
          end else begin
            state_nx   = DATA;
            cnt_nx     = FULL_LOAD;
            bit_idx_nx = '0;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_nx   = {rxs, shift[UART_DATA_W-1:1]};
          cnt_nx     = FULL_LOAD;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == '0) begin
          par_bad_nx = rxs ^ (^shift);
          frame_set  = rxs ^ (^shift);
          cnt_nx     = FULL_LOAD;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~par_bad;
`else
            push_req = 1'b1;
`endif
            state_nx = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nx  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers; the completed byte is staged one cycle before the FIFO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      push_q    <= push_req;
      push_data <= shift;
      busy      <= (state_nx != IDLE);
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_nx;
`endif
    end
  end

  assign pop     = bus.rd_en & ~fifo_empty;
  assign ovf_set = push_q & fifo_full & ~pop;

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set   | (overflow  & ~bus.clr_err);
      frame_err <= frame_set | (frame_err & ~bus.clr_err);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.rd_data)
  );

  assign bus.rd_valid  = ~fifo_empty;
  assign bus.overflow  = overflow;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Testbench for uart_rx_buffer: directed scenarios plus random frames against a queue model.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q[$];
  logic       exp_ovf;
  logic       exp_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic b);
    uart_rx = b;
    tick(BAUD);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".valid"}, 32'(bus.rd_valid), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, ".data"}, 32'(bus.rd_data), 32'(q[0]));
    check({tag, ".ovf"},  32'(bus.overflow),  32'(exp_ovf));
    check({tag, ".ferr"}, 32'(bus.frame_err), 32'(exp_ferr));
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pre_valid"}, 32'(bus.rd_valid), 32'(q.size() > 0));
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_status(tag);
  endtask

  task automatic clear_flags(input string tag);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    check_status(tag);
  endtask

  // mode 0: plain, 1: check push latency (FIFO empty), 2: pop in the push cycle.
  // Leaves the line at stop_val when the frame ends.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int mode);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^b);
`endif
    uart_rx = stop_val;
    for (int j = 1; j <= BAUD; j++) begin
      tick(1);
      if (mode == 1 && j == 11) check("latency.before", 32'(bus.rd_valid), 32'd0);
      if (mode == 1 && j == 12) check("latency.after",  32'(bus.rd_valid), 32'd1);
      if (mode == 2 && j == 11) begin
        check("simul.head", 32'(bus.rd_data), 32'(q[0]));
        bus.rd_en = 1'b1;
      end
      if (mode == 2 && j == 12) begin
        bus.rd_en = 1'b0;
        void'(q.pop_front());
      end
    end
    if (stop_val) begin
      if (q.size() < DEPTH) q.push_back(b);
      else                  exp_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         np;

    uart_rx     = 1'b1;
    reset       = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    exp_ovf     = 1'b0;
    exp_ferr    = 1'b0;

    // Reset values
    tick(3);
    check_status("reset");
    check("reset.data", 32'(bus.rd_data), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick(5);

    // Single frame with push latency, then one pop
    send_frame(8'hA5, 1'b1, 1);
    check_status("single");
    check("single.busy", 32'(bus.busy), 32'd0);
    pop_one("single.pop");

    // Glitch rejection
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    check("glitch.busy_on", 32'(bus.busy), 32'd1);
    tick(8);
    check("glitch.busy_off", 32'(bus.busy), 32'd0);
    check_status("glitch");
    tick(BAUD);

    // Overflow: five bytes into four slots
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 0);
    check_status("ovf");
    check("ovf.flag", 32'(bus.overflow), 32'd1);
    for (int k = 0; k < 4; k++) pop_one("ovf.pop");
    clear_flags("ovf.clr");

    // Simultaneous push and pop while full
    for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1, 0);
    send_frame(8'($urandom), 1'b1, 2);
    check_status("simul");
    for (int k = 0; k < 4; k++) pop_one("simul.pop");

    // Framing error followed by a long break
    send_frame(8'h3C, 1'b0, 0);
    check_status("frame");
    tick(15 * BAUD);
    check("break.busy", 32'(bus.busy), 32'd1);
    clear_flags("break.clr");
    tick(15 * BAUD);
    check_status("break.once");
    check("break.busy2", 32'(bus.busy), 32'd1);
    uart_rx = 1'b1;
    tick(4);
    check("break.release", 32'(bus.busy), 32'd0);
    tick(BAUD);
    send_frame(8'h3C, 1'b1, 0);
    check_status("frame.good");
    pop_one("frame.pop");

    // Reset during data bit 4 with a byte queued and frame_err set
    send_frame(8'($urandom), 1'b1, 0);
    send_frame(8'($urandom), 1'b0, 0);
    uart_rx = 1'b1;
    tick(BAUD);
    check_status("prereset");
    b = 8'($urandom);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    uart_rx = b[4];
    tick(BAUD / 2);
    reset = 1'b1;
    tick(1);
    reset   = 1'b0;
    uart_rx = 1'b1;
    q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    check_status("midreset");
    check("midreset.data", 32'(bus.rd_data), 32'd0);
    check("midreset.busy", 32'(bus.busy), 32'd0);
    tick(20 * BAUD);
    check_status("midreset.quiet");
    check("midreset.busy2", 32'(bus.busy), 32'd0);
    send_frame(8'h7E, 1'b1, 0);
    check_status("midreset.7e");
    pop_one("midreset.pop");

    // Random frames, pops and clears
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, 0);
      if (!stop) begin
        uart_rx = 1'b1;
        tick(BAUD);
      end
      check_status("rand");
      check("rand.busy", 32'(bus.busy), 32'd0);
      np = int'($urandom_range(0, 2));
      for (int p = 0; p < np; p++) begin
        if (q.size() > 0) pop_one("rand.pop");
      end
      if ($urandom_range(0, 3) == 0) clear_flags("rand.clr");
      tick(int'($urandom_range(0, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
